serial_mag_compare_ctrl: RTL and testbench
==========================================

Name: serial_mag_compare_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands using a single 2-bit magnitude compare slice (G/E/L outputs), one 2-bit digit per clock, MSB digit first.
- Trades latency for area: replaces a wide parallel comparator in the midterm datapath.
- Start/busy/done handshake; registered G/E/L result held until the next run completes.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. An odd value is an elaboration error.
- CNT_W, $clog2(WIDTH/2)+1, width of the digit index and the digits output.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare; accepted only when busy=0
- a  input  WIDTH  operand A, unsigned, sampled on the accepting edge
- b  input  WIDTH  operand B, unsigned, sampled on the accepting edge
- busy  output  1  high while digits are being compared
- done  output  1  one-cycle pulse; result valid and updated
- G  output  1  registered result: A > B
- E  output  1  registered result: A == B
- L  output  1  registered result: A < B
- digits  output  CNT_W  number of digits examined in the last completed run

Behaviour:
- Reset is asynchronous on rst_n=0: state=IDLE, busy=0, done=0, G=0, E=0, L=0, digits=0, internal operand/index/decision registers cleared.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 latches a and b, sets idx=WIDTH/2-1, clears the decided flag, sets digit count to 0, and enters RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge feeds digit pair {A[2idx+1:2idx], B[2idx+1:2idx]} to the slice and increments the digit count.
  - If the decided flag is clear and the slice reports G or L, capture that outcome and set the decided flag. Later digits never override the captured outcome.
  - Exit to DONE when idx==0 (see Optional Feature for early exit). Otherwise decrement idx.
- Entering DONE:
  - G/L take the captured outcome. E=1 only if no digit differed.
  - Exactly one of G/E/L is 1. digits takes the final count.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back runs) and the next state is RUN.
- start while busy=1 is ignored; the in-flight run is unaffected.
- Latency: done is asserted N edges after the start-accepting edge. N=WIDTH/2, or the 1-based position of the first differing digit under early exit.
- G/E/L/digits are held from one DONE to the next. They are not cleared on start. Only reset clears them.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Reset mid-run aborts immediately to the reset state. No done pulse is generated.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: RUN exits to DONE on the edge where the first differing digit is detected, or at idx==0, whichever comes first. digits reports the digits actually examined (1..WIDTH/2).
- Undefined: every run takes exactly WIDTH/2 RUN cycles and digits always equals WIDTH/2. Results are identical in both builds; only latency and digits differ.

Test Plan (WIDTH=8):
- Equal operands: a=0xB4, b=0xB4, start pulse -> done 4 edges after acceptance. G=0, E=1, L=0, digits=4, in both builds.
- MSB difference: a=0xC0, b=0x3F -> G=1, E=0, L=0. With the macro: done after 1 edge, digits=1. Without: done after 4 edges, digits=4.
- LSB difference: a=0x12, b=0x13 -> L=1 after 4 edges, digits=4, in both builds. Also a=0xFF, b=0x00 -> G=1.
- Busy protection: start pulsed again mid-run with new operands 0x00/0xFF -> ignored; the first run's result and timing are unchanged.
- Back-to-back: start held high through the DONE cycle with a=0x01, b=0x02 -> second run starts with no IDLE gap. The first result is held until the second done, then L=1.
- Reset mid-run: rst_n low for 1 cycle during RUN -> busy/done/G/E/L/digits read 0 immediately with no done pulse. A new start completes normally.

Source files
------------

// File: rtl/serial_mag_compare_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_mag_compare_ctrl_if
// Handshake and result bundle for the serial magnitude comparator.
//   master : requester side; drives start, a, b and observes the results
//   slave  : comparator side; receives start, a, b and drives the results
// Signals:
//   start        compare request (accepted only while busy=0)
//   a, b         WIDTH-bit unsigned operands, sampled on the accepting edge
//   busy         high while digits are being compared
//   done         one-cycle pulse when G/E/L/digits update
//   G, E, L      registered result: A>B, A==B, A<B
//   digits       number of 2-bit digits examined in the last run
// ---------------------------------------------------------------------------
interface serial_mag_compare_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH / 2) + 1
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             G;
  logic             E;
  logic             L;
  logic [CNT_W-1:0] digits;

  modport master (
    output start, a, b,
    input  busy, done, G, E, L, digits
  );

  modport slave (
    input  start, a, b,
    output busy, done, G, E, L, digits
  );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// ---------------------------------------------------------------------------
// serial_mag_compare_ctrl
// Compares two WIDTH-bit unsigned operands one 2-bit digit per clock, MSB
// digit first, through a single 2-bit G/E/L compare slice.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_mag_compare_ctrl_if.slave (start/a/b in;
//          busy/done/G/E/L/digits out)
// Optional feature macro: SERIAL_CMP_EARLY_EXIT_EN
//   defined   : a run stops on the first differing digit
//   undefined : every run takes WIDTH/2 RUN cycles
// Results are identical in both builds; only latency and digits differ.
// ---------------------------------------------------------------------------
module serial_mag_compare_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH / 2) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_mag_compare_ctrl_if.slave     bus
);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One 2-bit magnitude slice; returns {greater, less}.
  function automatic logic [1:0] cmp2(input logic [1:0] x, input logic [1:0] y);
    cmp2 = {(x > y), (x < y)};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d, digits_q, digits_d;
  logic             decided_q, decided_d, gt_q, gt_d;
  logic             g_q, g_d, e_q, e_d, l_q, l_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [1:0]       slice;
  logic             hit, dec_now, gt_now, exit_now;

  // Current digit pair: shift the latched operands right by 2*idx.
  assign a_sh  = a_q >> {idx_q, 1'b0};
  assign b_sh  = b_q >> {idx_q, 1'b0};
  assign slice = cmp2(a_sh[1:0], b_sh[1:0]);

  // Only the first differing digit is captured; later ones are ignored.
  assign hit      = !decided_q && (slice[1] || slice[0]);
  assign dec_now  = decided_q || hit;
  assign gt_now   = hit ? slice[1] : gt_q;
  assign exit_now = (idx_q == '0) || (EARLY_EXIT && hit);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    g_d       = g_q;
    e_d       = e_q;
    l_d       = l_q;
    digits_d  = digits_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          idx_d     = LAST_IDX;
          cnt_d     = '0;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          state_d   = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d     = cnt_q + CNT_W'(1);
        decided_d = dec_now;
        gt_d      = gt_now;
        if (exit_now) begin
          g_d      = dec_now && gt_now;
          l_d      = dec_now && !gt_now;
          e_d      = !dec_now;
          digits_d = cnt_q + CNT_W'(1);
          state_d  = DONE;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      g_q       <= 1'b0;
      e_q       <= 1'b0;
      l_q       <= 1'b0;
      digits_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      g_q       <= g_d;
      e_q       <= e_d;
      l_q       <= l_d;
      digits_q  <= digits_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.G      = g_q;
  assign bus.E      = e_q;
  assign bus.L      = l_q;
  assign bus.digits = digits_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_compare_ctrl
// Directed self-checking bench for serial_mag_compare_ctrl at WIDTH=8.
// Expected latency/digits follow SERIAL_CMP_EARLY_EXIT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_serial_mag_compare_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int MSB_LAT = 1;
`else
  localparam int MSB_LAT = 4;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  serial_mag_compare_ctrl_if #(.WIDTH(8)) bus ();

  serial_mag_compare_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launch one run and return the number of edges from acceptance to done
  // (-1 if done never arrives). Operands are scrambled after acceptance.
  task automatic do_run(input logic [7:0] av, input logic [7:0] bv, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'h5A;
    bus.b     = 8'hA5;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({bus.busy, bus.done, bus.G, bus.E, bus.L} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/G/E/L=%b expected 00000",
               {bus.busy, bus.done, bus.G, bus.E, bus.L});
    end
    n_cmp++;
    if (bus.digits !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_digits: got %0d expected 0", bus.digits);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy/done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_equal();
    int lat;
    do_run(8'hB4, 8'hB4, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL eq_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b010) begin
      n_fail++;
      $display("FAIL eq_gel: got %b expected 010", {bus.G, bus.E, bus.L});
    end
    n_cmp++;
    if (bus.digits !== 3'd4) begin
      n_fail++;
      $display("FAIL eq_digits: got %0d expected 4", bus.digits);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL eq_done_pulse: got done/busy=%b expected 00", {bus.done, bus.busy});
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b010) begin
      n_fail++;
      $display("FAIL eq_hold: got %b expected 010", {bus.G, bus.E, bus.L});
    end
  endtask

  task automatic test_msb_diff();
    int lat;
    do_run(8'hC0, 8'h3F, lat);
    n_cmp++;
    if (lat !== MSB_LAT) begin
      n_fail++;
      $display("FAIL msb_latency: got %0d expected %0d", lat, MSB_LAT);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b100) begin
      n_fail++;
      $display("FAIL msb_gel: got %b expected 100", {bus.G, bus.E, bus.L});
    end
    n_cmp++;
    if (bus.digits !== 3'(MSB_LAT)) begin
      n_fail++;
      $display("FAIL msb_digits: got %0d expected %0d", bus.digits, MSB_LAT);
    end
  endtask

  task automatic test_lsb_diff();
    int lat;
    do_run(8'h12, 8'h13, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL lsb_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b001) begin
      n_fail++;
      $display("FAIL lsb_gel: got %b expected 001", {bus.G, bus.E, bus.L});
    end
    n_cmp++;
    if (bus.digits !== 3'd4) begin
      n_fail++;
      $display("FAIL lsb_digits: got %0d expected 4", bus.digits);
    end
    do_run(8'hFF, 8'h00, lat);
    n_cmp++;
    if (lat !== MSB_LAT) begin
      n_fail++;
      $display("FAIL ff00_latency: got %0d expected %0d", lat, MSB_LAT);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b100) begin
      n_fail++;
      $display("FAIL ff00_gel: got %b expected 100", {bus.G, bus.E, bus.L});
    end
  endtask

  // Previous result is G (0xFF vs 0x00); this run is 0x12 vs 0x13 -> L.
  task automatic test_busy_protect();
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h13;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_asserted: got %b expected 1", bus.busy);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        n_cmp++;
        if ({bus.G, bus.E, bus.L} !== 3'b100) begin
          n_fail++;
          $display("FAIL busy_held_result: got %b expected 100", {bus.G, bus.E, bus.L});
        end
        bus.start = 1'b1;
        bus.a = 8'h00;
        bus.b = 8'hFF;
      end else if (i == 2) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL busy_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b001) begin
      n_fail++;
      $display("FAIL busy_gel: got %b expected 001", {bus.G, bus.E, bus.L});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_no_restart: got busy/done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hC0;
    bus.b = 8'h3F;
    @(posedge clk);
    #1;
    bus.a = 8'h01;
    bus.b = 8'h02;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat !== MSB_LAT) begin
      n_fail++;
      $display("FAIL b2b_first_latency: got %0d expected %0d", lat, MSB_LAT);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_first_gel: got %b expected 100", {bus.G, bus.E, bus.L});
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_no_gap: got busy/done=%b expected 10", {bus.busy, bus.done});
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (i == 1) begin
        n_cmp++;
        if ({bus.G, bus.E, bus.L} !== 3'b100) begin
          n_fail++;
          $display("FAIL b2b_held: got %b expected 100", {bus.G, bus.E, bus.L});
        end
      end
    end
    n_cmp++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL b2b_second_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_second_gel: got %b expected 001", {bus.G, bus.E, bus.L});
    end
  endtask

  task automatic test_reset_mid_run();
    int  lat;
    logic saw_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hB4;
    bus.b = 8'hB4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.G, bus.E, bus.L} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_flags: got busy/done/G/E/L=%b expected 00000",
               {bus.busy, bus.done, bus.G, bus.E, bus.L});
    end
    n_cmp++;
    if (bus.digits !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_digits: got %0d expected 0", bus.digits);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got activity=%b expected 0", saw_done);
    end
    do_run(8'h12, 8'h13, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL midrst_rerun_latency: got %0d expected 4", lat);
    end
    n_cmp++;
    if ({bus.G, bus.E, bus.L, bus.digits} !== {3'b001, 3'd4}) begin
      n_fail++;
      $display("FAIL midrst_rerun_result: got GEL=%b digits=%0d expected 001 / 4",
               {bus.G, bus.E, bus.L}, bus.digits);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_equal();
    test_msb_diff();
    test_lsb_diff();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
